lsu_align: RTL

//  Load/store alignment unit between the core's memory stage and DMEM (word-only storage, combinational read, write on posedge).

---
 rtl/lsu_align.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/lsu_align.sv
// ============================================================================
//  Module   : lsu_align
//  Purpose  : Load/store alignment unit between the memory stage and a
//             word-only DMEM. Converts byte/half/word accesses at any byte
//             address into word accesses. Sub-word stores use
//             read-modify-write, loads are sign/zero extended, and accesses
//             that cross a word boundary are split into two word accesses.
//  Options  : LSU_MISALIGN_TRAP_EN - crossing accesses are not split; they
//             answer with resp_err=1 and leave memory untouched.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_align #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_write_data,
    output logic              mem_MemRW,
    input  logic [31:0]       mem_read_data
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC0 = 2'd1,
        S_ACC1 = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic              we_q;
    logic              uns_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rd0_q;
    logic [23:0]       rd1_q;   // the second word never supplies more than 3 bytes

    logic [1:0]        off;
    logic [2:0]        nbytes;
    logic [3:0]        bmask4;
    logic [7:0]        lane_mask;
    logic [63:0]       wdata_sh;
    logic [31:0]       mask0, mask1;
    logic              crossing;
    logic              trap;
    logic [ADDR_W-1:0] word_base, word_next;
    logic [31:0]       raw, ld_data;

    assign off       = addr_q[1:0];
    assign crossing  = ({1'b0, off} + nbytes) > 3'd4;
    assign lane_mask = {4'b0000, bmask4} << off;
    assign wdata_sh  = {32'h0, wdata_q} << {off, 3'b000};
    assign word_base = {addr_q[ADDR_W-1:2], 2'b00};
    // Increment of the word index wraps naturally at 2^ADDR_W.
    assign word_next = {addr_q[ADDR_W-1:2] + {{(ADDR_W-3){1'b0}}, 1'b1}, 2'b00};

`ifdef LSU_MISALIGN_TRAP_EN
    assign trap = crossing;
`else
    assign trap = 1'b0;
`endif

    // Access width decode; size 11 is handled as a word.
    always_comb begin
        nbytes = 3'd4;
        bmask4 = 4'b1111;
        case (size_q)
            2'b00:   begin nbytes = 3'd1; bmask4 = 4'b0001; end
            2'b01:   begin nbytes = 3'd2; bmask4 = 4'b0011; end
            default: begin nbytes = 3'd4; bmask4 = 4'b1111; end
        endcase
    end

    // Expand lane enables into bit masks for the first and second word.
    always_comb begin
        mask0 = 32'h0;
        mask1 = 32'h0;
        for (int i = 0; i < 4; i++) begin
            mask0[8*i +: 8] = {8{lane_mask[i]}};
            mask1[8*i +: 8] = {8{lane_mask[i+4]}};
        end
    end

    // Little-endian assembly of load bytes starting at the byte offset, then extension.
    always_comb begin
        raw = rd0_q;
        case (off)
            2'd0: raw = rd0_q;
            2'd1: raw = {rd1_q[7:0],  rd0_q[31:8]};
            2'd2: raw = {rd1_q[15:0], rd0_q[31:16]};
            2'd3: raw = {rd1_q[23:0], rd0_q[31:24]};
            default: raw = rd0_q;
        endcase
        ld_data = raw;
        case (size_q)
            2'b00:   ld_data = uns_q ? {24'h0, raw[7:0]}  : {{24{raw[7]}},  raw[7:0]};
            2'b01:   ld_data = uns_q ? {16'h0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
            default: ld_data = raw;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Request capture on accept and read-data capture at the end of each access cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            rd0_q   <= 32'h0;
            rd1_q   <= 24'h0;
        end else begin
            if (state == S_IDLE && req_valid) begin
                we_q    <= req_we;
                uns_q   <= req_unsigned;
                size_q  <= req_size;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (state == S_ACC0) rd0_q <= mem_read_data;
            if (state == S_ACC1) rd1_q <= mem_read_data[23:0];
        end
    end

    // Next-state and output decode; every output is idle-zero unless its state drives it.
    always_comb begin
        state_nxt      = state;
        req_ready      = 1'b0;
        resp_valid     = 1'b0;
        resp_rdata     = 32'h0;
        resp_err       = 1'b0;
        mem_address    = '0;
        mem_write_data = 32'h0;
        mem_MemRW      = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = S_ACC0;
            end
            S_ACC0: begin
                mem_address = word_base;
                if (we_q && !trap) begin
                    mem_MemRW      = 1'b1;
                    mem_write_data = (mem_read_data & ~mask0) | (wdata_sh[31:0] & mask0);
                end
                state_nxt = (crossing && !trap) ? S_ACC1 : S_RESP;
            end
            S_ACC1: begin
                mem_address = word_next;
                if (we_q) begin
                    mem_MemRW      = 1'b1;
                    mem_write_data = (mem_read_data & ~mask1) | (wdata_sh[63:32] & mask1);
                end
                state_nxt = S_RESP;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                resp_err   = trap;
                if (!we_q && !trap) resp_rdata = ld_data;
                state_nxt  = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

`default_nettype wire
